ram_responder: RTL

- Word-organised RAM that answers the CPU's memory bus as the responder (slave).
- The core issues requests; this block captures them, inserts programmable wait states, commits writes with byte enables, returns read data and pulses a one-cycle acknowledge.
- Sits under `top` as the `ram` instance.
- Storage array is named `memory`, one 32-bit word per entry, so benches can preload it hierarchically with $readmemh.

---
 rtl/ram_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ram_responder.sv
// Word-organised RAM bus responder. Requests are captured, delayed by WAIT_CYCLES, then committed with a one-cycle ack.
// Optional: define RAM_RANGE_ERR_EN to flag out-of-range addresses with err_o instead of aliasing.
module ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [3:0]              r_sel;
  logic [31:0]             r_wdata;
  logic                    r_range_err;

  logic [31:0]             memory [0:DEPTH-1];

  logic                    w_capture;
  logic                    w_range_err;
  logic                    w_mem_we;
  logic                    w_mem_rd;
  logic                    w_ack_nxt;
  logic                    w_err_nxt;
  logic                    w_unused_addr;

  // The ack cycle is spent in IDLE, so a back-to-back request is taken at the edge that ends it.
  assign w_capture     = (r_state == S_IDLE) && req_i;
  assign w_unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

`ifdef RAM_RANGE_ERR_EN
  assign w_range_err = |addr_i[31:ADDR_WIDTH+2];
`else
  assign w_range_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise unlisted paths infer latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (req_i) w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_rd  = 1'b0;
    w_ack_nxt = 1'b0;
    w_err_nxt = 1'b0;
    if (r_state == S_RESP) begin
      w_mem_we  = r_we && !r_range_err;
      w_mem_rd  = !r_we && !r_range_err;
      w_ack_nxt = !r_range_err;
      w_err_nxt = r_range_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_sel       <= 4'd0;
      r_wdata     <= 32'd0;
      r_range_err <= 1'b0;
    end else if (w_capture) begin
      r_cnt       <= WAIT_INIT;
      r_we        <= we_i;
      r_idx       <= addr_i[ADDR_WIDTH+1:2];
      r_sel       <= sel_i;
      r_wdata     <= wdata_i;
      r_range_err <= w_range_err;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o <= w_ack_nxt;
      err_o <= w_err_nxt;
      if (w_mem_rd) rdata_o <= memory[r_idx];
    end
  end

  // NOTE: the storage array has no reset; contents survive rst and only change on a committed write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we && r_sel[b]) memory[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

endmodule
